farm_sensor_ctrl: RTL and testbench

FARM_SENSOR_CTRL -- requirements
Module: farm_sensor_ctrl

---
 rtl/farm_sensor_ctrl.sv | 144 ++++++++++++++
 tb/tb_farm_sensor_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/farm_sensor_ctrl.sv
// Farm-road vehicle sensor front end: synchronizes and debounces the loop, counts queued vehicles,
// and requests service from the traffic controller. Optional lamp-conflict monitor: FARM_SENSOR_CONFLICT_MON_EN.
module farm_sensor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WAIT_LIMIT      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_raw,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    output logic       C,
    output logic [3:0] queue_count,
    output logic       wait_timeout,
    output logic       conflict,
    output logic [1:0] fsm_state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SERVED = 2'd2
    } state_t;

    localparam logic [3:0] DEB_TGT  = 4'(DEBOUNCE_CYCLES);
    localparam logic [7:0] WAIT_TGT = 8'(WAIT_LIMIT);
    localparam logic [2:0] GREEN    = 3'b001;

    logic       s1_q, s1_d, s2_q, s2_d;
    logic       deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [3:0] queue_q, queue_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
    logic       c_q, c_d;
    state_t     state_q, state_d;
    logic       arrival, departure;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            queue_q    <= '0;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            c_q        <= 1'b0;
            state_q    <= IDLE;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            deb_cnt_q  <= deb_cnt_d;
            queue_q    <= queue_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            c_q        <= c_d;
            state_q    <= state_d;
        end
    end

    // Debounce run counter restarts on any cycle where the synchronized level agrees with deb.
    always_comb begin
        s1_d       = loop_raw;
        s2_d       = s1_q;
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        deb_prev_d = deb_q;
        if (s2_q != deb_q) begin
            if (deb_cnt_q + 4'd1 == DEB_TGT) begin
                deb_d = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 4'd1;
            end
        end
        arrival   = deb_q & ~deb_prev_q;
        departure = ~deb_q & deb_prev_q & (light_farm == GREEN);
        queue_d   = queue_q;
        if (arrival && queue_q != 4'd15) begin
            queue_d = queue_q + 4'd1;
        end else if (departure && queue_q != 4'd0) begin
            queue_d = queue_q - 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (queue_q != 4'd0) begin
                    state_d = REQ;
                    wait_d  = '0;
                end
            end
            REQ: begin
                wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
                if (light_farm == GREEN) begin
                    state_d   = SERVED;
                    timeout_d = 1'b0;
                end else if (wait_d >= WAIT_TGT) begin
                    timeout_d = 1'b1;
                end
            end
            SERVED: begin
                if (light_highway == GREEN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        c_d = (state_d == REQ);
    end

    assign C             = c_q;
    assign queue_count   = queue_q;
    assign wait_timeout  = timeout_q;
    assign fsm_state_dbg = state_q;

`ifdef FARM_SENSOR_CONFLICT_MON_EN
    logic conflict_q, conflict_d;
    logic pair_legal;

    always_comb begin
        case ({light_highway, light_farm})
            6'b001_100, 6'b010_100, 6'b100_001, 6'b100_010: pair_legal = 1'b1;
            default:                                         pair_legal = 1'b0;
        endcase
        conflict_d = conflict_q | ~pair_legal;
    end

    always_ff @(posedge clk) begin
        if (rst) conflict_q <= 1'b0;
        else     conflict_q <= conflict_d;
    end

    assign conflict = conflict_q;
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_farm_sensor_ctrl.sv
// Directed bench for farm_sensor_ctrl: a behavioural model checked every cycle plus literal checkpoints.
module tb_farm_sensor_ctrl;

    localparam int DEB  = 4;
    localparam int WLIM = 64;
`ifdef FARM_SENSOR_CONFLICT_MON_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       loop_raw;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       C;
    logic [3:0] queue_count;
    logic       wait_timeout;
    logic       conflict;
    logic [1:0] fsm_state_dbg;

    int n_vec = 0;
    int n_err = 0;

    farm_sensor_ctrl #(.DEBOUNCE_CYCLES(DEB), .WAIT_LIMIT(WLIM)) dut (
        .clk(clk), .rst(rst), .loop_raw(loop_raw),
        .light_highway(light_highway), .light_farm(light_farm),
        .C(C), .queue_count(queue_count), .wait_timeout(wait_timeout),
        .conflict(conflict), .fsm_state_dbg(fsm_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: loop level delayed two samples, accepted when the last DEB delayed samples all disagree
    // with the accepted level; queue and request phase follow the textual rules.
    bit m_s1, m_s2, m_deb, m_deb_prev, m_to, m_conf, m_c;
    bit hist[$];
    int m_q, m_phase, m_wait;
    bit all_diff, legal;
    int q_new;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0;
            m_to = 0; m_conf = 0; m_c = 0;
            m_q = 0; m_phase = 0; m_wait = 0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            all_diff = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;

            q_new = m_q;
            if (m_deb && !m_deb_prev) q_new = (m_q < 15) ? m_q + 1 : 15;
            else if (!m_deb && m_deb_prev && light_farm == 3'b001) q_new = (m_q > 0) ? m_q - 1 : 0;

            if (m_phase == 0) begin
                if (m_q > 0) begin m_phase = 1; m_wait = 0; end
            end else if (m_phase == 1) begin
                m_wait = (m_wait < 255) ? m_wait + 1 : 255;
                if (light_farm == 3'b001) begin m_phase = 2; m_to = 0; end
                else if (m_wait >= WLIM) m_to = 1;
            end else begin
                if (light_highway == 3'b001) m_phase = 0;
            end
            m_c = (m_phase == 1);

            legal = ({light_highway, light_farm} == 6'b001100) || ({light_highway, light_farm} == 6'b010100) ||
                    ({light_highway, light_farm} == 6'b100001) || ({light_highway, light_farm} == 6'b100010);
            if (CONF_EN && !legal) m_conf = 1;

            m_s2 = m_s1;
            m_s1 = loop_raw;
            m_deb_prev = m_deb;
            if (all_diff) m_deb = !m_deb;
            m_q = q_new;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_C", int'(C), int'(m_c));
        chk("model_queue", int'(queue_count), m_q);
        chk("model_timeout", int'(wait_timeout), int'(m_to));
        chk("model_conflict", int'(conflict), int'(m_conf));
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_loop(input bit v);
        @(negedge clk);
        loop_raw = v;
    endtask

    task automatic drive_lamps(input logic [2:0] hw, input logic [2:0] fm);
        @(negedge clk);
        light_highway = hw;
        light_farm    = fm;
    endtask

    initial begin
        rst = 1'b1; loop_raw = 1'b0; light_highway = 3'b001; light_farm = 3'b100;
        edges(3);
        chk("reset_C", int'(C), 0);
        chk("reset_queue", int'(queue_count), 0);
        chk("reset_timeout", int'(wait_timeout), 0);
        chk("reset_conflict", int'(conflict), 0);

        // short glitch shorter than the debounce window
        @(negedge clk); rst = 1'b0; loop_raw = 1'b1;
        repeat (3) @(negedge clk);
        loop_raw = 1'b0;
        edges(15);
        chk("glitch_queue", int'(queue_count), 0);
        chk("glitch_C", int'(C), 0);

        // first arrival latency
        drive_loop(1'b1);
        edges(6);
        chk("arr_e6_queue", int'(queue_count), 0);
        edges(1);
        chk("arr_e7_queue", int'(queue_count), 1);
        chk("arr_e7_C", int'(C), 0);
        edges(1);
        chk("arr_e8_C", int'(C), 1);

        // second arrival, then service cycle
        drive_loop(1'b0); edges(8);
        drive_loop(1'b1); edges(8);
        chk("q2_queue", int'(queue_count), 2);
        chk("q2_C", int'(C), 1);
        drive_lamps(3'b100, 3'b001);
        edges(1);
        chk("served_C", int'(C), 0);
        drive_loop(1'b0);
        edges(6);
        chk("dep_e6_queue", int'(queue_count), 2);
        edges(1);
        chk("dep_e7_queue", int'(queue_count), 1);
        drive_lamps(3'b001, 3'b100);
        edges(1);
        chk("idle_C", int'(C), 0);
        edges(1);
        chk("rereq_C", int'(C), 1);

        // wait timeout
        edges(63);
        chk("wait63_timeout", int'(wait_timeout), 0);
        edges(1);
        chk("wait64_timeout", int'(wait_timeout), 1);
        drive_lamps(3'b100, 3'b001);
        edges(1);
        chk("green_timeout", int'(wait_timeout), 0);
        chk("green_C", int'(C), 0);
        drive_lamps(3'b001, 3'b100);
        edges(2);
        chk("back_C", int'(C), 1);

        // saturation at 15 over 17 arrivals
        for (int i = 0; i < 17; i++) begin
            drive_loop(1'b1); edges(8);
            drive_loop(1'b0); edges(8);
        end
        chk("sat_queue", int'(queue_count), 15);

        // reset mid-operation with loop held high
        @(negedge clk); rst = 1'b1; loop_raw = 1'b1;
        edges(1);
        chk("midrst_C", int'(C), 0);
        chk("midrst_queue", int'(queue_count), 0);
        chk("midrst_timeout", int'(wait_timeout), 0);
        @(negedge clk); rst = 1'b0;
        edges(6);
        chk("postrst_e6_queue", int'(queue_count), 0);
        edges(1);
        chk("postrst_e7_queue", int'(queue_count), 1);

        // illegal lamp pair for one cycle
        drive_lamps(3'b001, 3'b001);
        edges(1);
        chk("conflict_set", int'(conflict), int'(CONF_EN));
        drive_lamps(3'b001, 3'b100);
        edges(5);
        chk("conflict_hold", int'(conflict), int'(CONF_EN));
        @(negedge clk); rst = 1'b1;
        edges(1);
        chk("conflict_rst", int'(conflict), 0);
        @(negedge clk); rst = 1'b0;
        edges(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
